// File: rtl/seq_divider_32_pkg.sv
// Shared ALU definitions: opcode constants for the divide/modulo operations and the
// state encoding of the sequential divider.
package seq_divider_32_pkg;

  localparam int DIV_WIDTH = 32;

  // ALU opcodes whose results come from the divider
  localparam logic [3:0] ALU_OP_DIV = 4'hA;
  localparam logic [3:0] ALU_OP_MOD = 4'hB;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_RUN  = 2'b01,
    DIV_FIN  = 2'b10
  } div_state_e;

endpackage : seq_divider_32_pkg

// File: rtl/seq_divider_32_div_step.sv
// One restoring-division step: shifts the next dividend bit into the partial remainder,
// trial-subtracts the divisor with a bit-level ripple subtractor, and keeps or restores.
module seq_divider_32_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             t_ge_d;

  // NOTE: every signal driven here gets a default at the top of the block; a path that
  // left one unassigned would infer a latch instead of combinational logic.
  always_comb begin
    t      = {r, q_msb};
    diff   = '0;
    borrow = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = t[i] ^ d[i] ^ borrow;
      borrow  = (~t[i] & d[i]) | (~(t[i] ^ d[i]) & borrow);
    end
    // The divisor's top bit is an implicit 0, so only t[WIDTH] can absorb the last borrow.
    t_ge_d = t[WIDTH] | ~borrow;
    q_bit  = t_ge_d;
    r_next = t_ge_d ? diff : t[WIDTH-1:0];
  end

endmodule : seq_divider_32_div_step

// File: rtl/seq_divider_32.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done handshake,
// quotient and remainder held until the next operation completes.
module seq_divider_32
  import seq_divider_32_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_e       state, state_next;
  logic [WIDTH-1:0] r_reg, q_reg, d_reg;
  logic [CW-1:0]    count;
  logic             accept;
  logic [WIDTH-1:0] r_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_next;

  seq_divider_32_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .r      (r_reg),
    .q_msb  (q_reg[WIDTH-1]),
    .d      (d_reg),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign q_next = {q_reg[WIDTH-2:0], q_bit};

  // A zero divisor bypasses RUN; FIN accepts a new start so operations can run back to back.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      DIV_IDLE, DIV_FIN: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (divisor == '0) ? DIV_FIN : DIV_RUN;
        end else begin
          state_next = DIV_IDLE;
        end
      end
      DIV_RUN: begin
        if (count == LAST_STEP) state_next = DIV_FIN;
      end
      default: state_next = DIV_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= DIV_IDLE;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        r_reg       <= '0;
        q_reg       <= dividend;
        d_reg       <= divisor;
        count       <= '0;
        div_by_zero <= (divisor == '0);
        if (divisor == '0) begin
          quotient  <= '1;
          remainder <= dividend;
        end
      end else if (state == DIV_RUN) begin
        r_reg <= r_next;
        q_reg <= q_next;
        count <= count + 1'b1;
        if (count == LAST_STEP) begin
          quotient  <= q_next;
          remainder <= r_next;
        end
      end
    end
  end

  assign busy = (state == DIV_RUN);
  assign done = (state == DIV_FIN);

endmodule : seq_divider_32

// File: tb/tb_seq_divider_32.sv
// Self-checking bench for seq_divider_32: directed vector table, hand-written handshake and
// reset sequences, and random operands checked against plain / and % arithmetic.
module tb_seq_divider_32;

  localparam int W       = 32;
  localparam int TIMEOUT = 100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  seq_divider_32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned divide, with the divide-by-zero convention q = all ones, r = dividend.
  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? '1 : a / b;
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  // Issues one start and waits (bounded) for done. lat = clock edges from the accepting
  // edge through the edge after which done is seen high.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  vec_t vecs[7];
  int   lat;
  int   done_seen;

  initial begin
    vecs[0] = '{a: 32'd100,        b: 32'd7, q: 32'd14,         r: 32'd2,    dz: 1'b0, lat: 33};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1, q: 32'hFFFF_FFFF,  r: 32'd0,    dz: 1'b0, lat: 33};
    vecs[2] = '{a: 32'd5,          b: 32'd9, q: 32'd0,          r: 32'd5,    dz: 1'b0, lat: 33};
    vecs[3] = '{a: 32'd1234,       b: 32'd0, q: 32'hFFFF_FFFF,  r: 32'd1234, dz: 1'b1, lat: 1};
    vecs[4] = '{a: 32'd9,          b: 32'd9, q: 32'd1,          r: 32'd0,    dz: 1'b0, lat: 33};
    vecs[5] = '{a: 32'd0,          b: 32'd5, q: 32'd0,          r: 32'd0,    dz: 1'b0, lat: 33};
    vecs[6] = '{a: 32'h8000_0000,  b: 32'hFFFF_FFFF, q: 32'd0,  r: 32'h8000_0000, dz: 1'b0, lat: 33};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_quotient", 64'(quotient), 64'd0);
    check("reset_remainder", 64'(remainder), 64'd0);
    check("reset_dz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      run_div(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_quotient", i), 64'(quotient), 64'(vecs[i].q));
      check($sformatf("vec%0d_remainder", i), 64'(remainder), 64'(vecs[i].r));
      check($sformatf("vec%0d_dz", i), 64'(div_by_zero), 64'(vecs[i].dz));
      check($sformatf("vec%0d_busy_in_fin", i), 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
    end

    // Start while busy is ignored; then a start in the FIN cycle runs back to back
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    repeat (9) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ignore_busy_high", 64'(busy), 64'd1);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    start = 1'b0;
    while (!done && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ignore_latency", 64'(lat), 64'd33);
    check("ignore_quotient", 64'(quotient), 64'd14);
    check("ignore_remainder", 64'(remainder), 64'd2);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_no_double_done", 64'(done), 64'd0);
    while (!done && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_latency", 64'(lat), 64'd33);
    check("b2b_quotient", 64'(quotient), 64'd10);
    check("b2b_remainder", 64'(remainder), 64'd0);

    // Back-to-back divides by zero: done stays high across both
    run_div(32'd77, 32'd0, lat);
    dividend = 32'd88;
    divisor  = 32'd0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("dz2_done", 64'(done), 64'd1);
    check("dz2_remainder", 64'(remainder), 64'd88);
    check("dz2_dz", 64'(div_by_zero), 64'd1);

    // Asynchronous reset in the middle of a division
    @(posedge clk);
    #1;
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_quotient", 64'(quotient), 64'd0);
    check("abort_remainder", 64'(remainder), 64'd0);
    check("abort_dz", 64'(div_by_zero), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    run_div(32'd9, 32'd3, lat);
    check("after_reset_quotient", 64'(quotient), 64'd3);
    check("after_reset_remainder", 64'(remainder), 64'd0);

    // Random operands against the arithmetic reference, with a hold check before the next start
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] a, b, eq, er;
      int           mode;
      int           idle;
      mode = int'($urandom_range(0, 3));
      a    = $urandom;
      b    = $urandom;
      case (mode)
        1:       b = a;
        2:       begin b = b | 32'h1; a = a % b; end
        3:       b = $urandom_range(1, 255);
        default: ;
      endcase
      eq = ref_q(a, b);
      er = ref_r(a, b);
      run_div(a, b, lat);
      check($sformatf("rnd%0d_latency", n), 64'(lat), 64'((b == 0) ? 1 : 33));
      check($sformatf("rnd%0d_quotient", n), 64'(quotient), 64'(eq));
      check($sformatf("rnd%0d_remainder", n), 64'(remainder), 64'(er));
      check($sformatf("rnd%0d_dz", n), 64'(div_by_zero), 64'(b == 0));
      idle = int'($urandom_range(0, 3));
      repeat (idle) @(posedge clk);
      #1;
      check($sformatf("rnd%0d_hold", n), {quotient, remainder}, {eq, er});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seq_divider_32
